clkgen_multi: RTL and testbench
===============================

CLKGEN_MULTI -- requirements
Module: clkgen_multi

Interface
REQ-001 SHALL have parameter NUM_CLKS, default 4, number of output clock channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of divide/high/phase fields.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16, settle length in refclk cycles (>=1).
REQ-004 SHALL derive CHAN_W = max(1, clog2(NUM_CLKS)).
REQ-005 SHALL have port refclk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port cfg_valid  input  1  config request.
REQ-008 SHALL have port cfg_ready  output  1  config can be accepted.
REQ-009 SHALL have port cfg_chan  input  CHAN_W  target channel index.
REQ-010 SHALL have port cfg_div  input  CNT_W  period in refclk cycles.
REQ-011 SHALL have port cfg_high  input  CNT_W  high time in refclk cycles.
REQ-012 SHALL have port cfg_phase  input  CNT_W  start delay in refclk cycles.
REQ-013 SHALL have port outclk  output  NUM_CLKS  generated clocks, registered.
REQ-014 SHALL have port locked  output  1  all channels running with current config, registered.

Function
REQ-015 SHALL implement states SETTLE, APPLY, LOCKED; cfg_ready = (state != APPLY), combinational.
REQ-016 SHALL accept config on any edge with cfg_valid && cfg_ready; accept → capture fields, state APPLY, locked 0, all outclk 0 on that edge.
REQ-017 SHALL in APPLY (one cycle) load captured div/high/phase into channel cfg_chan, then enter SETTLE with settle counter 0.
REQ-018 SHALL treat cfg_chan >= NUM_CLKS as accepted but discarded: no register change, APPLY still taken, relock still occurs.
REQ-019 SHALL in SETTLE hold all outclk 0, locked 0, count edges; on LOCK_CYCLES-th edge after SETTLE entry set locked 1, state LOCKED.
REQ-020 SHALL restart settle counter on config accepted during SETTLE (via APPLY).
REQ-021 SHALL in LOCKED, with k = 0 for first cycle locked=1, drive outclk[i]=1 iff k >= phase_i and ((k - phase_i) mod div_i) < high_i.
REQ-022 SHALL start all channels' k together at LOCKED entry, giving phase-aligned restart after every relock.
REQ-023 SHALL implement mod via per-channel wrapping counter 0..div_i-1 plus phase down-counter; no divider.
REQ-024 SHALL drive outclk[i] constant 0 when div_i == 0 or high_i == 0.
REQ-025 SHALL drive outclk[i] constant 1 after phase elapsed when high_i >= div_i (div_i >= 1), incl. div_i = 1.
REQ-026 SHALL keep unchanged channels' registers across reconfiguration of another channel; they also restart at LOCKED entry.
REQ-027 SHALL give rst priority over cfg_valid on the same edge.

Reset
REQ-028 SHALL on rst edge: state SETTLE, settle counter 0, locked 0, outclk all 0, every channel div=2 high=1 phase=0, captured fields 0.
REQ-029 SHALL hold cfg_ready = 1 during and after reset (state SETTLE).
REQ-030 SHALL assert locked on the LOCK_CYCLES-th edge with rst low after reset.

Verification (NUM_CLKS=4, LOCK_CYCLES=16 unless stated)
REQ-031 SHALL test reset: rst 3 cycles, release → locked 0 for 15 edges, 1 at 16th; outclk=0000 before; after, every bit 1,0,1,0... from k=0.
REQ-032 SHALL test config: ch1 div=5 high=2 phase=3 accepted at edge E → locked 0 at E, 1 at E+17; outclk[1] from k=0: 0,0,0,1,1,0,0,0,1,1...; ch0 still 1,0,1,0 aligned at k=0.
REQ-033 SHALL test degenerate: ch2 div=0 → const 0; ch3 div=4 high=7 → const 1; ch0 div=1 high=1 phase=2 → 0,0,1,1,1...
REQ-034 SHALL test handshake: cfg_valid held 2 cycles → second beat blocked (cfg_ready 0 in APPLY), accepted next cycle; second accept during SETTLE → locked 1 exactly 17 edges after last accept.
REQ-035 SHALL test NUM_CLKS=3: cfg_chan=3 div=9 → no channel changes, locked drops and returns after 17 edges, outputs match defaults.
REQ-036 SHALL test rst in LOCKED with cfg_valid=1 same edge → defaults restored, config ignored, locked 0, relock after 16 edges.

Source files
------------

// File: rtl/clkgen_multi.sv
// Multi-channel programmable clock generator: per-channel divide/high/phase,
// single-channel reconfiguration with a settle period before outputs resume phase-aligned.
module clkgen_multi #(
    parameter int unsigned NUM_CLKS    = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LOCK_CYCLES = 16,
    localparam int unsigned CHAN_W     = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic [CNT_W-1:0]    cfg_high,
    input  logic [CNT_W-1:0]    cfg_phase,
    output logic [NUM_CLKS-1:0] outclk,
    output logic                locked
);

    localparam int unsigned SET_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [1:0] StSettle = 2'd0;
    localparam logic [1:0] StApply  = 2'd1;
    localparam logic [1:0] StLocked = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic                locked_q, locked_d;
    logic [NUM_CLKS-1:0] out_q, out_d;

    logic [CHAN_W-1:0]   cap_chan_q, cap_chan_d;
    logic [CNT_W-1:0]    cap_div_q, cap_div_d;
    logic [CNT_W-1:0]    cap_high_q, cap_high_d;
    logic [CNT_W-1:0]    cap_phase_q, cap_phase_d;

    logic accept;
    logic run_next;
    logic lock_edge;

    assign cfg_ready = (state_q != StApply);
    assign accept    = cfg_valid && cfg_ready;
    assign run_next  = (state_d == StLocked);
    // All channels restart from k = 0 together on the edge that raises locked.
    assign lock_edge = run_next && (state_q != StLocked);

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        locked_d    = locked_q;
        cap_chan_d  = cap_chan_q;
        cap_div_d   = cap_div_q;
        cap_high_d  = cap_high_q;
        cap_phase_d = cap_phase_q;
        if (accept) begin
            cap_chan_d  = cfg_chan;
            cap_div_d   = cfg_div;
            cap_high_d  = cfg_high;
            cap_phase_d = cfg_phase;
            state_d     = StApply;
            locked_d    = 1'b0;
        end else begin
            case (state_q)
                StApply: begin
                    state_d  = StSettle;
                    settle_d = '0;
                end
                StSettle: begin
                    if (settle_q == SET_W'(LOCK_CYCLES - 1)) begin
                        state_d  = StLocked;
                        locked_d = 1'b1;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                StLocked: begin
                    state_d = StLocked;
                end
                default: begin
                    state_d  = StSettle;
                    settle_d = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= StSettle;
            settle_q    <= '0;
            locked_q    <= 1'b0;
            out_q       <= '0;
            cap_chan_q  <= '0;
            cap_div_q   <= '0;
            cap_high_q  <= '0;
            cap_phase_q <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            locked_q    <= locked_d;
            out_q       <= out_d;
            cap_chan_q  <= cap_chan_d;
            cap_div_q   <= cap_div_d;
            cap_high_q  <= cap_high_d;
            cap_phase_q <= cap_phase_d;
        end
    end

    for (genvar g = 0; g < NUM_CLKS; g++) begin : g_chan
        logic [CNT_W-1:0] div_q, high_q, phase_q;
        logic [CNT_W-1:0] ph_q, ph_d;
        logic [CNT_W-1:0] pos_q, pos_d;
        logic [CNT_W:0]   pos_inc;
        logic             load;
        logic             out_nx;

        // Out-of-range channel indices never match, so the write is dropped.
        assign load = (state_q == StApply) && (cap_chan_q == CHAN_W'(g));

        always_comb begin
            ph_d    = ph_q;
            pos_d   = pos_q;
            pos_inc = {1'b0, pos_q} + {{CNT_W{1'b0}}, 1'b1};
            if (lock_edge) begin
                ph_d  = phase_q;
                pos_d = '0;
            end else if (ph_q != '0) begin
                ph_d  = ph_q - CNT_W'(1);
                pos_d = '0;
            end else if (pos_inc >= {1'b0, div_q}) begin
                pos_d = '0;
            end else begin
                pos_d = pos_inc[CNT_W-1:0];
            end
            out_nx = run_next && (ph_d == '0) && (div_q != '0) && (high_q != '0)
                     && (pos_d < high_q);
        end

        assign out_d[g] = out_nx;

        always_ff @(posedge refclk) begin
            if (rst) begin
                div_q   <= CNT_W'(2);
                high_q  <= CNT_W'(1);
                phase_q <= '0;
                ph_q    <= '0;
                pos_q   <= '0;
            end else begin
                if (load) begin
                    div_q   <= cap_div_q;
                    high_q  <= cap_high_q;
                    phase_q <= cap_phase_q;
                end
                ph_q  <= ph_d;
                pos_q <= pos_d;
            end
        end
    end

    assign outclk = out_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_clkgen_multi.sv
// Bench for clkgen_multi: directed scenarios with literal expectations, then random
// traffic checked every cycle against an edge-count based reference model.
module tb_clkgen_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_chan = '0;
    logic [15:0] cfg_div = '0, cfg_high = '0, cfg_phase = '0;

    logic        ready4, ready3, locked4, locked3;
    logic [3:0]  outclk4;
    logic [2:0]  outclk3;

    always #5 clk = ~clk;

    clkgen_multi u_dut4 (
        .refclk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready4),
        .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .outclk(outclk4), .locked(locked4)
    );

    clkgen_multi #(.NUM_CLKS(3)) u_dut3 (
        .refclk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready3),
        .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .outclk(outclk3), .locked(locked3)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference model: locked and k are derived from the edge at which lock is due.
    int edge_n   = 0;
    int lock_at  = 0;
    int last_acc = -10;
    bit model_ok = 1'b0;
    int md[2][4], mh[2][4], mp[2][4];
    int nch[2] = '{4, 3};

    function automatic bit exp_bit(input int d, input int h, input int p, input int k);
        if (d == 0 || h == 0 || k < p) return 1'b0;
        return ((k - p) % d) < h;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                for (int u = 0; u < 2; u++)
                    for (int i = 0; i < 4; i++) begin
                        md[u][i] = 2; mh[u][i] = 1; mp[u][i] = 0;
                    end
                lock_at  = edge_n + 16;
                last_acc = -10;
                model_ok = 1'b1;
            end else if (cfg_valid && last_acc != edge_n - 1) begin
                for (int u = 0; u < 2; u++)
                    if (int'(cfg_chan) < nch[u]) begin
                        md[u][cfg_chan] = int'(cfg_div);
                        mh[u][cfg_chan] = int'(cfg_high);
                        mp[u][cfg_chan] = int'(cfg_phase);
                    end
                lock_at  = edge_n + 17;
                last_acc = edge_n;
            end
        end
    end

    initial begin
        int k;
        bit lk;
        logic [3:0] e4;
        logic [2:0] e3;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                lk = (edge_n >= lock_at);
                k  = edge_n - lock_at;
                e4 = '0;
                e3 = '0;
                for (int i = 0; i < 4; i++)
                    if (lk) e4[i] = exp_bit(md[0][i], mh[0][i], mp[0][i], k);
                for (int i = 0; i < 3; i++)
                    if (lk) e3[i] = exp_bit(md[1][i], mh[1][i], mp[1][i], k);
                chk("model_locked4", locked4, lk);
                chk("model_locked3", locked3, lk);
                chk("model_outclk4", outclk4, e4);
                chk("model_outclk3", outclk3, e3);
                chk("model_ready4", ready4, last_acc != edge_n);
                chk("model_ready3", ready3, last_acc != edge_n);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int ch, input int d, input int h, input int p);
        cfg_chan  = 2'(ch);
        cfg_div   = 16'(d);
        cfg_high  = 16'(h);
        cfg_phase = 16'(p);
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic settle_then_lock(input string nm);
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk({nm, "_settle"}, locked4, 1'b0);
            chk({nm, "_settle_out"}, outclk4, 4'h0);
        end
        cyc();
        chk({nm, "_lock"}, locked4, 1'b1);
    endtask

    initial begin
        logic [9:0] pat1;
        logic [5:0] pat0;
        logic [3:0] seq4 [4];
        pat1    = 10'h318;
        pat0    = 6'b111100;
        seq4[0] = 4'hF; seq4[1] = 4'h8; seq4[2] = 4'hF; seq4[3] = 4'h8;

        // Reset release: lock on 16th edge, default divide-by-2 from k = 0.
        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_ready", ready4, 1'b1);
        rst = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            chk("rst_settle", locked4, 1'b0);
            chk("rst_settle_out", outclk4, 4'h0);
        end
        cyc();
        chk("rst_lock", locked4, 1'b1);
        chk("rst_k0", outclk4, 4'hF);
        chk("rst_k0_n3", outclk3, 3'h7);
        cyc();
        chk("rst_k1", outclk4, 4'h0);
        cyc();
        chk("rst_k2", outclk4, 4'hF);

        // Out-of-range channel on the 3-channel instance.
        send(3, 9, 4, 0);
        chk("oor_unlock", locked3, 1'b0);
        chk("oor_ready", ready3, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("oor_settle", locked3, 1'b0);
        end
        cyc();
        chk("oor_lock", locked3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            chk("oor_n3_default", outclk3, (k % 2 == 0) ? 3'h7 : 3'h0);
            chk("oor_n4_ch3", outclk4, seq4[k]);
        end

        // Channel 1 reconfiguration with phase.
        send(1, 5, 2, 3);
        chk("cfg_unlock", locked4, 1'b0);
        chk("cfg_out0", outclk4, 4'h0);
        settle_then_lock("cfg");
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cyc();
            chk("cfg_ch1", outclk4[1], pat1[k]);
            chk("cfg_ch0", outclk4[0], k % 2 == 0);
        end

        // Degenerate settings.
        send(2, 0, 1, 0);
        cyc();
        send(3, 4, 7, 0);
        cyc();
        send(0, 1, 1, 2);
        settle_then_lock("degen");
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            chk("degen_ch2_zero", outclk4[2], 1'b0);
            chk("degen_ch3_one", outclk4[3], 1'b1);
            chk("degen_ch0_div1", outclk4[0], pat0[k]);
            chk("degen_ch1", outclk4[1], pat1[k]);
        end

        // Handshake: valid held through APPLY, accepted again in SETTLE.
        cfg_chan = 2'd2; cfg_div = 16'd6; cfg_high = 16'd3; cfg_phase = 16'd1;
        cfg_valid = 1'b1;
        cyc();
        chk("hs_ready_apply", ready4, 1'b0);
        cyc();
        chk("hs_ready_settle", ready4, 1'b1);
        chk("hs_locked", locked4, 1'b0);
        cfg_chan = 2'd1; cfg_div = 16'd3; cfg_high = 16'd1; cfg_phase = 16'd0;
        cyc();
        cfg_valid = 1'b0;
        chk("hs_second_accept", ready4, 1'b0);
        settle_then_lock("hs");

        // Reset wins over a same-edge config.
        rst = 1'b1;
        send(0, 7, 3, 0);
        rst = 1'b0;
        chk("rstcfg_locked", locked4, 1'b0);
        chk("rstcfg_ready", ready4, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            cyc();
            chk("rstcfg_settle", locked4, 1'b0);
        end
        cyc();
        chk("rstcfg_lock", locked4, 1'b1);
        chk("rstcfg_k0", outclk4, 4'hF);
        chk("rstcfg_k0_n3", outclk3, 3'h7);
        cyc();
        chk("rstcfg_k1", outclk4, 4'h0);

        // Random traffic, checked by the model process.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 599) == 0);
            cfg_valid = ($urandom_range(0, 29) == 0);
            cfg_chan  = 2'($urandom_range(0, 3));
            cfg_div   = 16'($urandom_range(0, 7));
            cfg_high  = 16'($urandom_range(0, 8));
            cfg_phase = 16'($urandom_range(0, 5));
            cyc();
        end
        rst = 1'b0;
        cfg_valid = 1'b0;
        repeat (40) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
